// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit + colon seven-segment scan driver.
// It follows an external scan code, enforces dead time between slots and latches a tear-free frame snapshot.
module seg_scan_driver #(
    parameter int unsigned DEAD_CYCLES = 2,
    parameter logic        ACTIVE_LOW  = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [2:0]  sel_i,
    input  logic [15:0] digits_i,
    input  logic        colon_i,
    input  logic        blank_lz_i,
    output logic [4:0]  anode_o,
    output logic [6:0]  seg_o,
    output logic        seq_err_o,
    output logic        frame_o
);

    localparam logic [3:0] DEAD_LOAD = 4'(DEAD_CYCLES - 1);
    localparam logic [4:0] ANODE_OFF = {5{ACTIVE_LOW}};
    localparam logic [6:0] SEG_OFF   = {7{ACTIVE_LOW}};

    typedef enum logic [1:0] {RESYNC, DEAD, ON} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  sel_reg;
    logic [3:0]  cnt_reg, cnt_next;
    logic [15:0] snap_digits_reg;
    logic        snap_colon_reg;
    logic        snap_lz_reg;
    logic        err_reg;
    logic        frame_reg;
    logic [4:0]  anode_reg;
    logic [6:0]  seg_reg;

    logic        step, legal, illegal, capture, err_set;
    logic [2:0]  succ;
    logic        succ_valid;
    logic [4:0]  anode_act;
    logic [6:0]  seg_act;
    logic [3:0]  nib [4];
    logic [6:0]  digit_seg [4];
    logic [3:0]  blank;

    function automatic logic [6:0] bcd7(input logic [3:0] v);
        case (v)
            4'd0:    bcd7 = 7'h3F;
            4'd1:    bcd7 = 7'h06;
            4'd2:    bcd7 = 7'h5B;
            4'd3:    bcd7 = 7'h4F;
            4'd4:    bcd7 = 7'h66;
            4'd5:    bcd7 = 7'h6D;
            4'd6:    bcd7 = 7'h7D;
            4'd7:    bcd7 = 7'h07;
            4'd8:    bcd7 = 7'h7F;
            4'd9:    bcd7 = 7'h6F;
            default: bcd7 = 7'h40;
        endcase
    endfunction

    // Leading-zero suppression chains from the most significant digit down; digit0 always shows.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = snap_lz_reg & (nib[3] == 4'd0);
        blank[2] = blank[3] & (nib[2] == 4'd0);
        blank[1] = blank[2] & (nib[1] == 4'd0);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign nib[gi]       = snap_digits_reg[gi*4 +: 4];
            assign digit_seg[gi] = blank[gi] ? 7'h00 : bcd7(nib[gi]);
        end
    endgenerate

    always_comb begin
        succ       = 3'b000;
        succ_valid = 1'b1;
        case (sel_reg)
            3'b000:  succ = 3'b001;
            3'b001:  succ = 3'b011;
            3'b011:  succ = 3'b100;
            3'b100:  succ = 3'b010;
            3'b010:  succ = 3'b000;
            default: succ_valid = 1'b0;
        endcase
    end

    assign step    = (sel_i != sel_reg);
    assign legal   = step & succ_valid & (sel_i == succ);
    assign illegal = step & ~legal;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            RESYNC: begin
                if (step && sel_i == 3'b000) begin
                    state_next = DEAD;
                    cnt_next   = DEAD_LOAD;
                    capture    = 1'b1;
                end
            end
            DEAD, ON: begin
                if (illegal) begin
                    state_next = RESYNC;
                    err_set    = 1'b1;
                end else if (legal) begin
                    state_next = DEAD;
                    cnt_next   = DEAD_LOAD;
                    capture    = (sel_i == 3'b000);
                end else if (state_reg == DEAD) begin
                    if (cnt_reg == 4'd0) begin
                        state_next = ON;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
            end
            default: state_next = RESYNC;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with the FSM.
    always_comb begin
        anode_act = 5'b00000;
        seg_act   = 7'h00;
        if (state_next == ON) begin
            case (sel_reg)
                3'b000: begin anode_act = 5'b00001; seg_act = digit_seg[0]; end
                3'b001: begin anode_act = 5'b00010; seg_act = digit_seg[1]; end
                3'b011: begin anode_act = 5'b00100; seg_act = digit_seg[2]; end
                3'b100: begin anode_act = 5'b01000; seg_act = digit_seg[3]; end
                3'b010: begin anode_act = 5'b10000; seg_act = snap_colon_reg ? 7'h03 : 7'h00; end
                default: begin anode_act = 5'b00000; seg_act = 7'h00; end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg       <= RESYNC;
            sel_reg         <= 3'b000;
            cnt_reg         <= 4'd0;
            snap_digits_reg <= 16'h0000;
            snap_colon_reg  <= 1'b0;
            snap_lz_reg     <= 1'b0;
            err_reg         <= 1'b0;
            frame_reg       <= 1'b0;
            anode_reg       <= ANODE_OFF;
            seg_reg         <= SEG_OFF;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_i;
            cnt_reg   <= cnt_next;
            err_reg   <= err_reg | err_set;
            frame_reg <= capture;
            if (capture) begin
                snap_digits_reg <= digits_i;
                snap_colon_reg  <= colon_i;
                snap_lz_reg     <= blank_lz_i;
            end
            anode_reg <= anode_act ^ ANODE_OFF;
            seg_reg   <= seg_act ^ SEG_OFF;
        end
    end

    assign anode_o   = anode_reg;
    assign seg_o     = seg_reg;
    assign seq_err_o = err_reg;
    assign frame_o   = frame_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (DEAD_CYCLES=2, active-low outputs).
// Each scan slot is held 4 cycles: 2 dead cycles followed by 2 lit cycles.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [2:0]  sel_i;
    logic [15:0] digits_i;
    logic        colon_i;
    logic        blank_lz_i;
    logic [4:0]  anode_o;
    logic [6:0]  seg_o;
    logic        seq_err_o;
    logic        frame_o;

    int checks = 0;
    int errors = 0;
    logic [2:0] seq_tab [5];
    logic [6:0] exp_tab [5];

    always #5 clk = ~clk;

    seg_scan_driver #(.DEAD_CYCLES(2), .ACTIVE_LOW(1'b1)) dut (
        .clk_i(clk), .reset_i(reset_i), .sel_i(sel_i), .digits_i(digits_i),
        .colon_i(colon_i), .blank_lz_i(blank_lz_i), .anode_o(anode_o),
        .seg_o(seg_o), .seq_err_o(seq_err_o), .frame_o(frame_o)
    );

    task automatic cyc(input logic [2:0] s);
        sel_i = s;
        @(posedge clk);
        #1;
    endtask

    // Full frame 000,001,011,100,010; exp_tab holds active-high segment patterns per slot.
    task automatic scan_frame(input string tag, input int late_slot, input logic [15:0] late_digits);
        logic [4:0] one;
        logic [4:0] exp_an;
        logic [6:0] exp_sg;
        logic       exp_fr;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (i == late_slot && k == 0) digits_i = late_digits;
                cyc(seq_tab[i]);
                one    = 5'b00001 << i;
                exp_an = (k < 2) ? 5'h1F : ~one;
                exp_sg = (k < 2) ? 7'h7F : ~exp_tab[i];
                exp_fr = (i == 0 && k == 0);
                checks++;
                if (anode_o !== exp_an || seg_o !== exp_sg) begin
                    errors++;
                    $display("FAIL %s slot%0d cyc%0d: anode_o=%b seg_o=%b, expected anode=%b seg=%b",
                             tag, i, k, anode_o, seg_o, exp_an, exp_sg);
                end
                checks++;
                if (frame_o !== exp_fr) begin
                    errors++;
                    $display("FAIL %s_frame slot%0d cyc%0d: frame_o=%b expected %b", tag, i, k, frame_o, exp_fr);
                end
            end
        end
        $display("frame %s scanned", tag);
    endtask

    task automatic test_reset;
        reset_i = 1'b1; sel_i = 3'b000; digits_i = 16'h0000; colon_i = 1'b0; blank_lz_i = 1'b0;
        repeat (3) cyc(3'b000);
        checks++;
        if (anode_o !== 5'h1F || seg_o !== 7'h7F) begin
            errors++; $display("FAIL reset_outputs: anode_o=%b seg_o=%b expected 11111/1111111", anode_o, seg_o);
        end
        checks++;
        if (seq_err_o !== 1'b0 || frame_o !== 1'b0) begin
            errors++; $display("FAIL reset_flags: seq_err_o=%b frame_o=%b expected 0/0", seq_err_o, frame_o);
        end
        reset_i = 1'b0;
        $display("reset applied");
    endtask

    task automatic test_resync_idle;
        for (int i = 0; i < 5; i++) begin
            repeat (4) begin
                cyc(seq_tab[i]);
                checks++;
                if (anode_o !== 5'h1F || seg_o !== 7'h7F || frame_o !== 1'b0) begin
                    errors++;
                    $display("FAIL resync_idle sel=%b: anode_o=%b seg_o=%b frame_o=%b expected blank, no frame",
                             seq_tab[i], anode_o, seg_o, frame_o);
                end
            end
        end
        $display("resync idle pass through scan order");
    endtask

    task automatic test_basic;
        digits_i = 16'h1234; colon_i = 1'b1; blank_lz_i = 1'b0;
        exp_tab = '{7'h66, 7'h4F, 7'h5B, 7'h06, 7'h03};
        scan_frame("basic_1234", -1, 16'h0000);
        checks++;
        if (seq_err_o !== 1'b0) begin
            errors++; $display("FAIL basic_err: seq_err_o=%b expected 0", seq_err_o);
        end
    endtask

    task automatic test_blank_lz;
        colon_i = 1'b0;
        digits_i = 16'h0007; blank_lz_i = 1'b1;
        exp_tab = '{7'h07, 7'h00, 7'h00, 7'h00, 7'h00};
        scan_frame("lz_on_0007", -1, 16'h0000);
        blank_lz_i = 1'b0;
        exp_tab = '{7'h07, 7'h3F, 7'h3F, 7'h3F, 7'h00};
        scan_frame("lz_off_0007", -1, 16'h0000);
        digits_i = 16'h0050; blank_lz_i = 1'b1;
        exp_tab = '{7'h3F, 7'h6D, 7'h00, 7'h00, 7'h00};
        scan_frame("lz_on_0050", -1, 16'h0000);
    endtask

    task automatic test_snapshot;
        digits_i = 16'h1234; colon_i = 1'b0; blank_lz_i = 1'b0;
        exp_tab = '{7'h66, 7'h4F, 7'h5B, 7'h06, 7'h00};
        scan_frame("snap_hold", 2, 16'h5678);
        exp_tab = '{7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h00};
        scan_frame("snap_new", -1, 16'h0000);
    endtask

    task automatic test_dead_retarget;
        digits_i = 16'h1234;
        repeat (4) cyc(3'b000);
        cyc(3'b001);
        cyc(3'b011);
        cyc(3'b011);
        checks++;
        if (anode_o !== 5'h1F) begin
            errors++; $display("FAIL dead_reload: anode_o=%b expected 11111 (counter reloaded)", anode_o);
        end
        cyc(3'b011);
        checks++;
        if (anode_o !== 5'b11011 || seg_o !== ~7'h5B) begin
            errors++; $display("FAIL dead_retarget: anode_o=%b seg_o=%b expected 11011/%b", anode_o, seg_o, ~7'h5B);
        end
        cyc(3'b011);
        repeat (4) cyc(3'b100);
        repeat (4) cyc(3'b010);
        $display("dead-time retarget to digit2");
    endtask

    task automatic test_seq_error;
        repeat (4) cyc(3'b000);
        repeat (3) cyc(3'b001);
        checks++;
        if (anode_o !== 5'b11101) begin
            errors++; $display("FAIL err_pre_on: anode_o=%b expected 11101", anode_o);
        end
        cyc(3'b100);
        checks++;
        if (seq_err_o !== 1'b1 || anode_o !== 5'h1F || seg_o !== 7'h7F) begin
            errors++; $display("FAIL err_jump: seq_err_o=%b anode_o=%b seg_o=%b expected 1/11111/1111111",
                               seq_err_o, anode_o, seg_o);
        end
        repeat (3) cyc(3'b100);
        repeat (4) cyc(3'b010);
        checks++;
        if (anode_o !== 5'h1F || seq_err_o !== 1'b1) begin
            errors++; $display("FAIL err_resync_blank: anode_o=%b seq_err_o=%b expected 11111/1", anode_o, seq_err_o);
        end
        exp_tab = '{7'h66, 7'h4F, 7'h5B, 7'h06, 7'h00};
        scan_frame("after_resync", -1, 16'h0000);
        checks++;
        if (seq_err_o !== 1'b1) begin
            errors++; $display("FAIL err_sticky: seq_err_o=%b expected 1", seq_err_o);
        end
    endtask

    task automatic test_illegal_code;
        reset_i = 1'b1;
        cyc(3'b000);
        reset_i = 1'b0;
        checks++;
        if (seq_err_o !== 1'b0) begin
            errors++; $display("FAIL err_cleared: seq_err_o=%b expected 0", seq_err_o);
        end
        digits_i = 16'h000C; colon_i = 1'b0; blank_lz_i = 1'b0;
        repeat (2) cyc(3'b010);
        repeat (3) cyc(3'b000);
        checks++;
        if (anode_o !== 5'b11110 || seg_o !== ~7'h40) begin
            errors++; $display("FAIL dash_pre: anode_o=%b seg_o=%b expected 11110/%b", anode_o, seg_o, ~7'h40);
        end
        cyc(3'b111);
        checks++;
        if (seq_err_o !== 1'b1 || anode_o !== 5'h1F || seg_o !== 7'h7F) begin
            errors++; $display("FAIL code_111: seq_err_o=%b anode_o=%b seg_o=%b expected 1/11111/1111111",
                               seq_err_o, anode_o, seg_o);
        end
        cyc(3'b111);
        repeat (2) cyc(3'b010);
        exp_tab = '{7'h40, 7'h3F, 7'h3F, 7'h3F, 7'h00};
        scan_frame("dash_000C", -1, 16'h0000);
    endtask

    task automatic test_reset_override;
        repeat (4) cyc(3'b000);
        repeat (3) cyc(3'b001);
        checks++;
        if (anode_o !== 5'b11101) begin
            errors++; $display("FAIL ovr_pre_on: anode_o=%b expected 11101", anode_o);
        end
        reset_i = 1'b1;
        cyc(3'b011);
        checks++;
        if (anode_o !== 5'h1F || seg_o !== 7'h7F || seq_err_o !== 1'b0 || frame_o !== 1'b0) begin
            errors++; $display("FAIL ovr_reset: anode_o=%b seg_o=%b seq_err_o=%b frame_o=%b expected blank, 0, 0",
                               anode_o, seg_o, seq_err_o, frame_o);
        end
        reset_i = 1'b0;
        repeat (4) begin
            cyc(3'b011);
            checks++;
            if (anode_o !== 5'h1F) begin
                errors++; $display("FAIL ovr_resync: anode_o=%b expected 11111 (still resyncing)", anode_o);
            end
        end
        $display("reset override mid-slot");
    endtask

    initial begin
        seq_tab = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b010};
        test_reset();
        test_resync_idle();
        test_basic();
        test_blank_lz();
        test_snapshot();
        test_dead_retarget();
        test_seq_error();
        test_illegal_code();
        test_reset_override();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
